// File: rtl/fir_pkg.sv
// Shared widths and types for the 3-tap FIR datapath and its downstream stages.
package fir_pkg;
  localparam int FIR_DW    = 9;
  localparam int FIR_DECIM = 4;
  localparam int FIR_CW    = 2;
  localparam int FIR_DEPTH = 4;
  localparam int FIR_AW    = 2;

  typedef logic [FIR_DW-1:0]        sample_t;
  typedef logic [FIR_DW+FIR_CW-1:0] gsum_t;
endpackage

// File: rtl/fir_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a synchronous flush.
module fir_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_level;
  logic             w_wr, w_rd;

  assign empty = (r_level == '0);
  assign full  = (r_level == (AW+1)'(DEPTH));
  assign level = r_level;

  // A write into a full FIFO is accepted only when the head leaves in the same cycle.
  assign w_rd = pop & ~empty;
  assign w_wr = push & (~full | w_rd);

  // Empty reads return zero so the head is defined without resetting the storage.
  assign rdata = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (w_wr && !clear) r_mem[r_wptr] <= wdata;
  end
endmodule

// File: rtl/fir_decim_buffer.sv
// Decimate-by-DECIM boxcar summer for the FIR output stream, queued for a valid/ready consumer.
module fir_decim_buffer
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int DECIM = FIR_DECIM,
  parameter int CW    = FIR_CW,
  parameter int DEPTH = FIR_DEPTH,
  parameter int AW    = FIR_AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW+CW-1:0] out_data,
  output logic [AW:0]     level,
  output logic            ovf
);
  logic [CW-1:0]    r_phase, w_phase_nxt;
  logic [DW+CW-1:0] r_acc, w_acc_nxt, w_sum;
  logic             r_ovf;
  logic             w_last, w_push, w_pop, w_empty, w_full, w_drop;

  assign w_sum  = r_acc + (DW+CW)'(in_data);
  assign w_last = in_valid & (r_phase == CW'(DECIM-1));
  assign w_push = w_last & ~clear;
  assign w_pop  = out_valid & out_ready & ~clear;
  assign w_drop = w_push & w_full & ~w_pop;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    w_phase_nxt = r_phase;
    w_acc_nxt   = r_acc;
    if (in_valid) begin
      w_phase_nxt = r_phase + 1'b1;
      w_acc_nxt   = (r_phase == '0) ? (DW+CW)'(in_data) : w_sum;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_phase <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_acc   <= w_acc_nxt;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  fir_sync_fifo #(
    .WIDTH (DW+CW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (w_push),
    .wdata (w_sum),
    .pop   (w_pop),
    .rdata (out_data),
    .empty (w_empty),
    .full  (w_full),
    .level (level)
  );

  assign out_valid = ~w_empty;
  assign ovf       = r_ovf;
endmodule
